// File: rtl/pipelined_barrel_shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation modes and
// the reserved-mode decode used to flag unsupported operations.
package barrel_pkg;

    localparam int MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_ROL = 3'b000,
        MODE_ROR = 3'b001,
        MODE_SLL = 3'b010,
        MODE_SRL = 3'b011,
        MODE_SRA = 3'b100
    } mode_e;

    // Codes above SRA have no defined operation; such data passes unshifted.
    function automatic logic is_reserved_mode(input logic [MODE_W-1:0] mode);
        return (mode > MODE_SRA);
    endfunction

endpackage

// File: rtl/pipelined_barrel_shifter_if.sv
// Operand/result handshake bundle for the pipelined barrel shifter.
// The master side is the upstream producer plus downstream consumer; the
// slave side is the shifter itself.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 8
);
    import barrel_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic [SHW-1:0]        in_amt;
    logic [MODE_W-1:0]     in_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_err;
    logic                  out_zero;

    modport master (
        output in_valid, in_data, in_amt, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_err, out_zero
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_err, out_zero
    );

endinterface

// File: rtl/pipelined_barrel_shifter_stage.sv
// One log2 step of the barrel shifter: when the amount bit is set, shift or
// rotate by 2**STAGE according to the mode; otherwise pass data through.
module shifter_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STAGE = 0
) (
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_bit,
    input  logic [MODE_W-1:0] i_mode,
    output logic [WIDTH-1:0]  o_data
);

    localparam int S = 1 << STAGE;

    logic signed [WIDTH-1:0] w_sdata;
    logic        [WIDTH-1:0] w_rol;
    logic        [WIDTH-1:0] w_ror;
    logic        [WIDTH-1:0] w_sll;
    logic        [WIDTH-1:0] w_srl;
    logic        [WIDTH-1:0] w_sra;

    assign w_sdata = i_data;
    assign w_rol   = {i_data[WIDTH-S-1:0], i_data[WIDTH-1:WIDTH-S]};
    assign w_ror   = {i_data[S-1:0], i_data[WIDTH-1:S]};
    assign w_sll   = i_data << S;
    assign w_srl   = i_data >> S;
    assign w_sra   = w_sdata >>> S;

    // Pick this step's result; reserved modes and a clear amount bit pass data.
    always_comb begin
        o_data = i_data;
        if (i_bit) begin
            case (i_mode)
                MODE_ROL: o_data = w_rol;
                MODE_ROR: o_data = w_ror;
                MODE_SLL: o_data = w_sll;
                MODE_SRL: o_data = w_srl;
                MODE_SRA: o_data = w_sra;
                default:  o_data = i_data;
            endcase
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SHW registered stages, stage k applying amount
// bit k. A single advance signal stalls every stage together, so the
// pipeline behaves as a strict FIFO with full-rate throughput.
module pipelined_barrel_shifter
    import barrel_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pipelined_barrel_shifter_if.slave    bus
);

    localparam int SHW = $clog2(WIDTH);

    // Control fields that travel alongside the data through each stage.
    typedef struct packed {
        logic [SHW-1:0]    amt;
        logic [MODE_W-1:0] mode;
        logic              err;
    } ctl_t;

    logic             w_advance;

    logic             r_vld_p    [SHW];
    logic [WIDTH-1:0] r_data_p   [SHW];
    ctl_t             r_ctl_p    [SHW];

    logic             w_stg_vld  [SHW];
    logic [WIDTH-1:0] w_stg_data [SHW];
    ctl_t             w_stg_ctl  [SHW];
    logic [WIDTH-1:0] w_shf_data [SHW];

    // The pipeline moves whenever the output slot is empty or being drained.
    assign w_advance     = !r_vld_p[SHW-1] || bus.out_ready;
    assign bus.in_ready  = w_advance;
    assign bus.out_valid = r_vld_p[SHW-1];
    assign bus.out_data  = r_data_p[SHW-1];
    assign bus.out_err   = r_ctl_p[SHW-1].err;
    assign bus.out_zero  = (r_data_p[SHW-1] == '0);

    // Stage sources: the input port feeds stage 0, each register feeds the next.
    always_comb begin
        w_stg_vld[0]  = bus.in_valid;
        w_stg_data[0] = bus.in_data;
        w_stg_ctl[0]  = '{amt: bus.in_amt, mode: bus.in_mode,
                          err: is_reserved_mode(bus.in_mode)};
        for (int k = 1; k < SHW; k++) begin
            w_stg_vld[k]  = r_vld_p[k-1];
            w_stg_data[k] = r_data_p[k-1];
            w_stg_ctl[k]  = r_ctl_p[k-1];
        end
    end

    genvar g;
    for (g = 0; g < SHW; g++) begin : g_stage
        shifter_stage #(
            .WIDTH (WIDTH),
            .STAGE (g)
        ) u_stage (
            .i_data (w_stg_data[g]),
            .i_bit  (w_stg_ctl[g].amt[g]),
            .i_mode (w_stg_ctl[g].mode),
            .o_data (w_shf_data[g])
        );
    end

    // Stage registers: cleared on reset, all loaded together on advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SHW; k++) begin
                r_vld_p[k]  <= 1'b0;
                r_data_p[k] <= '0;
                r_ctl_p[k]  <= '0;
            end
        end else if (w_advance) begin
            for (int k = 0; k < SHW; k++) begin
                r_vld_p[k]  <= w_stg_vld[k];
                r_data_p[k] <= w_shf_data[k];
                r_ctl_p[k]  <= w_stg_ctl[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter at WIDTH 8, 32 and 2.
module tb_pipelined_barrel_shifter;
    import barrel_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t q8[$];
    exp_t q32[$];
    exp_t q2[$];
    exp_t e8, e32, e2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_barrel_shifter_if #(.WIDTH(8))  b8 ();
    pipelined_barrel_shifter_if #(.WIDTH(32)) b32 ();
    pipelined_barrel_shifter_if #(.WIDTH(2))  b2 ();

    pipelined_barrel_shifter #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    pipelined_barrel_shifter #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(b32));
    pipelined_barrel_shifter #(.WIDTH(2))  u_dut2  (.clk(clk), .rst_n(rst_n), .bus(b2));

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Monitors: pop the oldest expectation on every output handshake.
    always @(negedge clk) begin
        if (b8.out_valid && b8.out_ready) begin
            if (q8.size() == 0) chk("w8_unexpected_out", 32'(b8.out_valid), 0);
            else begin
                e8 = q8.pop_front();
                chk("w8_data", 32'(b8.out_data), e8.data);
                chk("w8_err",  32'(b8.out_err),  32'(e8.err));
                chk("w8_zero", 32'(b8.out_zero), 32'(e8.data == 0));
                if (e8.lat) chk("w8_latency", cyc - e8.cyc, 3);
            end
        end
    end

    always @(negedge clk) begin
        if (b32.out_valid && b32.out_ready) begin
            if (q32.size() == 0) chk("w32_unexpected_out", 32'(b32.out_valid), 0);
            else begin
                e32 = q32.pop_front();
                chk("w32_data", b32.out_data, e32.data);
                chk("w32_err",  32'(b32.out_err), 32'(e32.err));
                if (e32.lat) chk("w32_latency", cyc - e32.cyc, 5);
            end
        end
    end

    always @(negedge clk) begin
        if (b2.out_valid && b2.out_ready) begin
            if (q2.size() == 0) chk("w2_unexpected_out", 32'(b2.out_valid), 0);
            else begin
                e2 = q2.pop_front();
                chk("w2_data", 32'(b2.out_data), e2.data);
                chk("w2_err",  32'(b2.out_err),  32'(e2.err));
                if (e2.lat) chk("w2_latency", cyc - e2.cyc, 1);
            end
        end
    end

    task automatic send8(input logic [7:0] d, input logic [2:0] a, input logic [2:0] m,
                         input logic [7:0] ed, input logic ee, input bit lat, input bit push);
        exp_t x;
        int   t = 0;
        b8.in_valid = 1'b1; b8.in_data = d; b8.in_amt = a; b8.in_mode = m;
        @(negedge clk);
        while (!b8.in_ready && t < 100) begin @(negedge clk); t++; end
        if (!b8.in_ready) chk("w8_in_ready_timeout", 32'(b8.in_ready), 1);
        else if (push) begin
            x.data = 32'(ed); x.err = ee; x.cyc = cyc; x.lat = lat;
            q8.push_back(x);
        end
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
    endtask

    task automatic send32(input logic [31:0] d, input logic [4:0] a, input logic [2:0] m,
                          input logic [31:0] ed, input logic ee);
        exp_t x;
        int   t = 0;
        b32.in_valid = 1'b1; b32.in_data = d; b32.in_amt = a; b32.in_mode = m;
        @(negedge clk);
        while (!b32.in_ready && t < 100) begin @(negedge clk); t++; end
        if (!b32.in_ready) chk("w32_in_ready_timeout", 32'(b32.in_ready), 1);
        else begin
            x.data = ed; x.err = ee; x.cyc = cyc; x.lat = 1'b1;
            q32.push_back(x);
        end
        @(posedge clk); #1;
        b32.in_valid = 1'b0;
    endtask

    task automatic send2(input logic [1:0] d, input logic a, input logic [2:0] m,
                         input logic [1:0] ed, input logic ee);
        exp_t x;
        int   t = 0;
        b2.in_valid = 1'b1; b2.in_data = d; b2.in_amt = a; b2.in_mode = m;
        @(negedge clk);
        while (!b2.in_ready && t < 100) begin @(negedge clk); t++; end
        if (!b2.in_ready) chk("w2_in_ready_timeout", 32'(b2.in_ready), 1);
        else begin
            x.data = 32'(ed); x.err = ee; x.cyc = cyc; x.lat = 1'b1;
            q2.push_back(x);
        end
        @(posedge clk); #1;
        b2.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q8.size() != 0 || q32.size() != 0 || q2.size() != 0) && t < 200) begin
            @(negedge clk); t++;
        end
        chk("drain_q8",  q8.size(),  0);
        chk("drain_q32", q32.size(), 0);
        chk("drain_q2",  q2.size(),  0);
        @(posedge clk); #1;
    endtask

    logic [7:0] stream_exp [6];

    initial begin
        stream_exp = '{8'h81, 8'h03, 8'h06, 8'h0C, 8'h18, 8'h30};
        rst_n = 1'b0;
        b8.in_valid  = 1'b0; b8.in_data  = '0; b8.in_amt  = '0; b8.in_mode  = '0; b8.out_ready  = 1'b1;
        b32.in_valid = 1'b0; b32.in_data = '0; b32.in_amt = '0; b32.in_mode = '0; b32.out_ready = 1'b1;
        b2.in_valid  = 1'b0; b2.in_data  = '0; b2.in_amt  = '0; b2.in_mode  = '0; b2.out_ready  = 1'b1;

        #12;
        chk("rst_out_valid", 32'(b8.out_valid), 0);
        chk("rst_out_data",  32'(b8.out_data),  0);
        chk("rst_out_err",   32'(b8.out_err),   0);
        chk("rst_out_zero",  32'(b8.out_zero),  1);
        chk("rst_in_ready",  32'(b8.in_ready),  1);
        chk("rst_w32_valid", 32'(b32.out_valid), 0);
        chk("rst_w2_zero",   32'(b2.out_zero),  1);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back pair: equal latency implies consecutive outputs.
        send8(8'hCC, 3'd1, MODE_ROL, 8'h99, 1'b0, 1'b1, 1'b1);
        send8(8'hF0, 3'd3, MODE_ROR, 8'h1E, 1'b0, 1'b1, 1'b1);
        send8(8'h90, 3'd2, MODE_SRA, 8'hE4, 1'b0, 1'b1, 1'b1);
        send8(8'h90, 3'd2, MODE_SRL, 8'h24, 1'b0, 1'b1, 1'b1);
        send8(8'h81, 3'd7, MODE_SLL, 8'h80, 1'b0, 1'b1, 1'b1);
        send8(8'h01, 3'd0, MODE_SLL, 8'h01, 1'b0, 1'b1, 1'b1);
        send8(8'h01, 3'd1, MODE_SRL, 8'h00, 1'b0, 1'b1, 1'b1);
        send8(8'h5A, 3'd5, 3'b111,   8'h5A, 1'b1, 1'b1, 1'b1);
        send8(8'h5A, 3'd4, MODE_ROL, 8'hA5, 1'b0, 1'b1, 1'b1);
        send8(8'h80, 3'd7, MODE_SRA, 8'hFF, 1'b0, 1'b1, 1'b1);
        drain();

        // Six-op stream with a four-cycle output stall.
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send8(8'h81, i[2:0], MODE_ROL, stream_exp[i], 1'b0, 1'b0, 1'b1);
            end
            begin
                int         t = 0;
                logic [7:0] held;
                do begin @(posedge clk); #1; t++; end while (!b8.out_valid && t < 50);
                if (!b8.out_valid) chk("stall_wait_valid", 32'(b8.out_valid), 1);
                b8.out_ready = 1'b0;
                held = b8.out_data;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    chk("stall_in_ready",  32'(b8.in_ready),  0);
                    chk("stall_out_valid", 32'(b8.out_valid), 1);
                    chk("stall_out_hold",  32'(b8.out_data),  32'(held));
                end
                @(posedge clk); #1;
                b8.out_ready = 1'b1;
                @(negedge clk);
                chk("stall_release_in_ready", 32'(b8.in_ready), 1);
            end
        join
        drain();

        // Asynchronous reset with two operations in flight.
        b8.out_ready = 1'b0;
        send8(8'h11, 3'd1, MODE_SLL, 8'h22, 1'b0, 1'b0, 1'b0);
        send8(8'h22, 3'd1, MODE_SLL, 8'h44, 1'b0, 1'b0, 1'b0);
        begin
            int t = 0;
            while (!b8.out_valid && t < 20) begin @(posedge clk); #1; t++; end
            chk("rstmid_valid_before", 32'(b8.out_valid), 1);
        end
        #3 rst_n = 1'b0;
        #2;
        chk("rstmid_out_valid", 32'(b8.out_valid), 0);
        chk("rstmid_in_ready",  32'(b8.in_ready),  1);
        chk("rstmid_out_data",  32'(b8.out_data),  0);
        chk("rstmid_out_zero",  32'(b8.out_zero),  1);
        #10 rst_n = 1'b1;
        b8.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rstmid_no_stale", 32'(b8.out_valid), 0);
        end
        @(posedge clk); #1;
        send8(8'h5A, 3'd4, MODE_ROL, 8'hA5, 1'b0, 1'b1, 1'b1);
        drain();

        // Wide and minimal widths.
        send32(32'h8000_0001, 5'd31, MODE_ROL, 32'hC000_0000, 1'b0);
        send32(32'h8000_0000, 5'd31, MODE_SRA, 32'hFFFF_FFFF, 1'b0);
        send32(32'h8000_0000, 5'd31, MODE_SRL, 32'h0000_0001, 1'b0);
        send2(2'b01, 1'b1, MODE_ROR, 2'b10, 1'b0);
        send2(2'b10, 1'b1, MODE_SRA, 2'b11, 1'b0);
        send2(2'b11, 1'b1, MODE_SLL, 2'b10, 1'b0);
        send2(2'b01, 1'b1, 3'b101,   2'b01, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined successor to the team's 8-bit combinational rotate-only shifter.
- Supports any power-of-two WIDTH and five shift/rotate modes.
- One log2 stage per pipeline register, with a valid/ready handshake on both sides.
- Sits between an upstream operand producer and a downstream consumer in the datapath; throughput is one operation per clock when not back-pressured.

Parameters:
- WIDTH, 8, data width in bits; must be a power of two and at least 2.
- SHW, $clog2(WIDTH), localparam (derived, not overridable): shift-amount width, and also the pipeline depth.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream offers an operation this cycle.
- in_ready  out  1  block accepts the operation this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  SHW  shift/rotate amount, 0..WIDTH-1.
- in_mode  in  3  000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA; 101-111 reserved.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  result.
- out_err  out  1  result came from a reserved mode.
- out_zero  out  1  out_data == 0; combinational decode of the output register.

Behaviour:
- Reset (rst_n low, asynchronous): every stage valid bit clears, every data, mode and error register clears.
  - Output values: out_valid=0, out_data=0, out_err=0, out_zero=1, in_ready=1.
  - In-flight operations are discarded, never emitted after release.
- Pipeline structure: stages 0..SHW-1; stage k applies amount bit k (shift by 2^k) and registers its result.
  - Per-stage registered fields: valid, data, remaining amount bits, mode, err.
- Stall control: advance = !out_valid || out_ready; in_ready = advance.
  - When advance=1, every stage loads from its predecessor; stage 0 loads from the inputs with valid = in_valid.
  - When advance=0, all stage registers hold.
  - Input handshake completes when in_valid && in_ready; output handshake completes when out_valid && out_ready.
  - out_ready=1 with out_valid=0 is legal and harmless.
- Latency: an operation accepted at rising edge N appears on out_valid after edge N+SHW-1 (SHW registered stages). Bubbles propagate as valid=0.
- Throughput: one operation per cycle while out_ready stays high. Ordering is strictly FIFO; no drops, no duplicates.
- Mode arithmetic per stage, with s = 2^k when amount bit k is set:
  - ROL: bits rotate left by s.
  - ROR: bits rotate right by s.
  - SLL: left shift by s, zero fill from the LSB.
  - SRL: right shift by s, zero fill from the MSB.
  - SRA: right shift by s, fill with the current MSB. Cumulative result equals in_data >>> in_amt, sign-preserving.
- Boundary conditions:
  - in_amt=0 passes data unchanged in every mode.
  - in_amt=WIDTH-1 is legal: SLL of 1 gives the MSB only; SRA of a negative value gives all ones.
  - Reserved mode: data passes unshifted through all stages and out_err=1; out_err=0 otherwise.
  - Simultaneous output handshake and input acceptance in the same cycle is required and sustains full rate.
  - Upstream must hold in_data, in_amt and in_mode stable while in_valid && !in_ready; the block samples only on the handshake.
  - WIDTH=2 gives SHW=1, a single stage and latency 1.

Decomposition:
- Package barrel_pkg holds:
  - the mode enum (ROL, ROR, SLL, SRL, SRA) and a mode-width constant of 3;
  - an is_reserved_mode function.
- Sub-module shifter_stage is parametrised by WIDTH and STAGE.
  - Combinational function of one stage: data, amount bit and mode in; shifted data out.
  - Instantiated SHW times in a generate loop.
  - The pipeline registers and the handshake stay in the top.

Test Plan (WIDTH=8, latency 3 unless noted):
- ROL 0xCC amt 1, then ROR 0xF0 amt 3 back-to-back with out_ready=1 -> out_data 0x99 then 0x1E on consecutive cycles; out_err=0.
- SRA 0x90 amt 2 -> 0xE4; SRL 0x90 amt 2 -> 0x24; SLL 0x81 amt 7 -> 0x80; SLL 0x01 amt 0 -> 0x01; SRL 0x01 amt 1 -> 0x00 with out_zero=1.
- Mode 3'b111, data 0x5A, amt 5 -> out_data 0x5A, out_err=1; next op ROL 0x5A amt 4 -> 0xA5, out_err=0.
- Stream 6 ops back-to-back; hold out_ready=0 for 4 cycles after the first out_valid -> in_ready=0 for exactly those cycles, outputs held stable, all 6 results emerge in order with none lost.
- Two ops in flight, pulse rst_n low mid-cycle -> out_valid drops immediately (asynchronous); after release no stale result appears and a new op returns correctly 3 cycles later.
- WIDTH=32 (latency 5): ROL 0x80000001 amt 31 -> 0xC0000000; SRA 0x80000000 amt 31 -> 0xFFFFFFFF. WIDTH=2: ROR 2'b01 amt 1 -> 2'b10 after 1 cycle.
